// File: rtl/datapath.sv
// datapath: 32-bit single-bus CPU datapath.
// Bus-connected registers R2, R4, R5, PC, IR, MAR, MDR, Y and the 64-bit Z.
// A combinational ALU takes A = Y and B = bus. A priority bus multiplexer
// selects one register onto the shared bus. An external sequencer drives
// every strobe and enable directly, one micro-step per clock.
module datapath (
  input  logic        Clock,
  input  logic        Clear,
  input  logic [31:0] MData_In,
  input  logic        Read,
  input  logic [4:0]  CONTROL,
  input  logic        IncPC,
  input  logic        R2_Out,
  input  logic        R4_Out,
  input  logic        PC_Out,
  input  logic        ZLO_Out,
  input  logic        MDR_Out,
  input  logic        R2_In,
  input  logic        R4_In,
  input  logic        R5_In,
  input  logic        PC_In,
  input  logic        IR_In,
  input  logic        MAR_In,
  input  logic        MDR_In,
  input  logic        Y_In,
  input  logic        Z_In,
  output logic [31:0] BusMux_Out
);

  // Slots in the bank of plain bus-loaded registers.
  localparam int IDX_R2  = 0;
  localparam int IDX_R4  = 1;
  localparam int IDX_R5  = 2;
  localparam int IDX_PC  = 3;
  localparam int IDX_IR  = 4;
  localparam int IDX_MAR = 5;
  localparam int IDX_Y   = 6;
  localparam int NREG    = 7;

  // ALU operation codes.
  localparam logic [4:0] OP_ADD  = 5'd0;
  localparam logic [4:0] OP_AND  = 5'd1;
  localparam logic [4:0] OP_OR   = 5'd2;
  localparam logic [4:0] OP_SUB  = 5'd3;
  localparam logic [4:0] OP_MUL  = 5'd4;
  localparam logic [4:0] OP_DIV  = 5'd5;
  localparam logic [4:0] OP_SHR  = 5'd6;
  localparam logic [4:0] OP_SHL  = 5'd7;
  localparam logic [4:0] OP_SHRA = 5'd8;
  localparam logic [4:0] OP_ROR  = 5'd9;
  localparam logic [4:0] OP_ROL  = 5'd10;
  localparam logic [4:0] OP_NEG  = 5'd11;
  localparam logic [4:0] OP_NOT  = 5'd12;

  logic [31:0] gpr_q [NREG];
  logic [31:0] gpr_d [NREG];
  logic [NREG-1:0] load_en;
  logic [31:0] mdr_q, mdr_d;
  logic [63:0] z_q, z_d;
  logic [31:0] bus;
  logic [63:0] alu_result;

  // Load enables, packed in the same order as the register slots.
  assign load_en = {Y_In, MAR_In, IR_In, PC_In, R5_In, R4_In, R2_In};

  // Bus mux: fixed priority MDR > ZLO > PC > R2 > R4; idle bus reads 0.
  always_comb begin
    bus = 32'h0;
    if (MDR_Out)      bus = mdr_q;
    else if (ZLO_Out) bus = z_q[31:0];
    else if (PC_Out)  bus = gpr_q[IDX_PC];
    else if (R2_Out)  bus = gpr_q[IDX_R2];
    else if (R4_Out)  bus = gpr_q[IDX_R4];
  end

  assign BusMux_Out = bus;

  // Each plain register takes the bus when enabled and holds otherwise.
  // Loading a register from its own bus drive is safe: the bus only
  // reflects the pre-edge value.
  generate
    for (genvar gi = 0; gi < NREG; gi++) begin : g_gpr_next
      assign gpr_d[gi] = load_en[gi] ? bus : gpr_q[gi];
    end
  endgenerate

  // MDR chooses between memory read data and the bus.
  always_comb begin
    mdr_d = mdr_q;
    if (MDR_In) mdr_d = Read ? MData_In : bus;
  end

  // Z captures the full 64-bit ALU result.
  always_comb begin
    z_d = z_q;
    if (Z_In) z_d = alu_result;
  end

  // ALU operand views and helper results.
  logic [31:0]        op_a, op_b;
  logic [4:0]         sh_amt;
  logic signed [63:0] mul_prod;
  logic [63:0]        ror_full, rol_full;
  logic [31:0]        shra_res;
  logic               div_by_zero, div_ovf;
  logic signed [31:0] div_den, div_quo, div_rem;

  assign op_a   = gpr_q[IDX_Y];
  assign op_b   = bus;
  assign sh_amt = op_b[4:0];

  // Sign-extend both operands to 64 bits so the truncated product is the
  // exact signed 64-bit result.
  assign mul_prod = $signed({{32{op_a[31]}}, op_a}) * $signed({{32{op_b[31]}}, op_b});

  // Rotates are taken from a doubled copy of A so no 32-bit shift is needed.
  assign ror_full = {op_a, op_a} >> sh_amt;
  assign rol_full = {op_a, op_a} << sh_amt;
  assign shra_res = $signed(op_a) >>> sh_amt;

  // Division guards: a zero divisor has its own defined result, and
  // INT_MIN / -1 would trap in a software model, so both divide by 1 here.
  // INT_MIN / 1 already gives the wrapped quotient INT_MIN with remainder 0.
  assign div_by_zero = (op_b == 32'h0);
  assign div_ovf     = (op_a == 32'h8000_0000) && (op_b == 32'hFFFF_FFFF);
  assign div_den     = (div_by_zero || div_ovf) ? 32'sd1 : $signed(op_b);
  assign div_quo     = $signed(op_a) / div_den;
  assign div_rem     = $signed(op_a) % div_den;

  // ALU result select; IncPC overrides the operation code.
  always_comb begin
    alu_result = 64'h0;
    if (IncPC) begin
      alu_result = {32'h0, op_b + 32'd1};
    end else begin
      case (CONTROL)
        OP_ADD:  alu_result = {32'h0, op_a + op_b};
        OP_AND:  alu_result = {32'h0, op_a & op_b};
        OP_OR:   alu_result = {32'h0, op_a | op_b};
        OP_SUB:  alu_result = {32'h0, op_a - op_b};
        OP_MUL:  alu_result = mul_prod;
        OP_DIV: begin
          if (div_by_zero) alu_result = {op_a, 32'hFFFF_FFFF};
          else             alu_result = {div_rem, div_quo};
        end
        OP_SHR:  alu_result = {32'h0, op_a >> sh_amt};
        OP_SHL:  alu_result = {32'h0, op_a << sh_amt};
        OP_SHRA: alu_result = {32'h0, shra_res};
        OP_ROR:  alu_result = {32'h0, ror_full[31:0]};
        OP_ROL:  alu_result = {32'h0, rol_full[63:32]};
        OP_NEG:  alu_result = {32'h0, 32'h0 - op_b};
        OP_NOT:  alu_result = {32'h0, ~op_b};
        default: alu_result = 64'h0;
      endcase
    end
  end

  // State update; Clear zeroes everything at once and overrides every enable.
  always_ff @(posedge Clock or posedge Clear) begin
    if (Clear) begin
      for (int i = 0; i < NREG; i++) gpr_q[i] <= 32'h0;
      mdr_q <= 32'h0;
      z_q   <= 64'h0;
    end else begin
      for (int i = 0; i < NREG; i++) gpr_q[i] <= gpr_d[i];
      mdr_q <= mdr_d;
      z_q   <= z_d;
    end
  end

endmodule

// File: tb/tb_datapath.sv
// tb_datapath: directed micro-step sequences for the datapath.
// Stimulus pushes each expected value into a scoreboard queue. A monitor pops
// and compares on the falling edge of any step that is marked observable.
module tb_datapath;

  logic        Clock = 1'b0;
  logic        Clear;
  logic [31:0] MData_In;
  logic        Read;
  logic [4:0]  CONTROL;
  logic        IncPC;
  logic        R2_Out, R4_Out, PC_Out, ZLO_Out, MDR_Out;
  logic        R2_In, R4_In, R5_In, PC_In, IR_In, MAR_In, MDR_In, Y_In, Z_In;
  logic [31:0] BusMux_Out;

  datapath dut (
    .Clock(Clock), .Clear(Clear), .MData_In(MData_In), .Read(Read),
    .CONTROL(CONTROL), .IncPC(IncPC),
    .R2_Out(R2_Out), .R4_Out(R4_Out), .PC_Out(PC_Out), .ZLO_Out(ZLO_Out), .MDR_Out(MDR_Out),
    .R2_In(R2_In), .R4_In(R4_In), .R5_In(R5_In), .PC_In(PC_In), .IR_In(IR_In),
    .MAR_In(MAR_In), .MDR_In(MDR_In), .Y_In(Y_In), .Z_In(Z_In),
    .BusMux_Out(BusMux_Out)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    bit          is_zhi;
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t        sb_q[$];
  bit          obs_valid = 1'b0;
  int          n_cmp = 0;
  int          n_bad = 0;
  exp_t        mon_item;
  logic [31:0] mon_act;

  // Monitor: compare the bus (or ZHI) against the oldest expectation.
  always @(negedge Clock) begin
    if (obs_valid) begin
      n_cmp++;
      if (sb_q.size() == 0) begin
        n_bad++;
        $display("FAIL scoreboard_empty: got %h with no expected value queued", BusMux_Out);
      end else begin
        mon_item = sb_q.pop_front();
        mon_act  = mon_item.is_zhi ? dut.z_q[63:32] : BusMux_Out;
        if (mon_act !== mon_item.exp) begin
          n_bad++;
          $display("FAIL %s: got %h expected %h", mon_item.name, mon_act, mon_item.exp);
        end else begin
          $display("ok   %s: got %h", mon_item.name, mon_act);
        end
      end
    end
  end

  task automatic clr_ctl();
    Read = 0; CONTROL = 5'd0; IncPC = 0;
    R2_Out = 0; R4_Out = 0; PC_Out = 0; ZLO_Out = 0; MDR_Out = 0;
    R2_In = 0; R4_In = 0; R5_In = 0; PC_In = 0; IR_In = 0;
    MAR_In = 0; MDR_In = 0; Y_In = 0; Z_In = 0;
  endtask

  // One micro-step: controls are already set; optionally queue an expectation.
  task automatic cyc(input bit chk, input bit is_zhi, input logic [31:0] exp, input string name);
    exp_t e;
    if (chk) begin
      e.is_zhi = is_zhi; e.exp = exp; e.name = name;
      sb_q.push_back(e);
      obs_valid = 1'b1;
    end else begin
      obs_valid = 1'b0;
    end
    @(posedge Clock);
    #1;
    obs_valid = 1'b0;
    clr_ctl();
  endtask

  task automatic step();
    cyc(1'b0, 1'b0, 32'h0, "");
  endtask

  task automatic chk_bus(input logic [31:0] exp, input string name);
    cyc(1'b1, 1'b0, exp, name);
  endtask

  task automatic chk_zhi(input logic [31:0] exp, input string name);
    cyc(1'b1, 1'b1, exp, name);
  endtask

  // Load Y = a via MDR, drive b via MDR into the ALU, then read ZLO and ZHI.
  task automatic alu_op(input logic [31:0] a, input logic [31:0] b, input logic [4:0] ctl,
                        input bit inc, input logic [31:0] lo, input logic [31:0] hi,
                        input string name);
    MData_In = a; Read = 1; MDR_In = 1; step();
    MDR_Out = 1; Y_In = 1; step();
    MData_In = b; Read = 1; MDR_In = 1; step();
    MDR_Out = 1; CONTROL = ctl; IncPC = inc; Z_In = 1; step();
    ZLO_Out = 1; chk_bus(lo, {name, "_lo"});
    chk_zhi(hi, {name, "_hi"});
  endtask

  initial begin
    clr_ctl();
    MData_In = 32'h0;
    Clear = 1'b1;
    repeat (2) @(posedge Clock);
    #1;
    Clear = 1'b0;

    // Reset state: every source reads zero.
    chk_bus(32'h0, "rst_idle");
    chk_zhi(32'h0, "rst_zhi");
    MDR_Out = 1; chk_bus(32'h0, "rst_mdr");
    ZLO_Out = 1; chk_bus(32'h0, "rst_zlo");
    PC_Out  = 1; chk_bus(32'h0, "rst_pc");
    R2_Out  = 1; chk_bus(32'h0, "rst_r2");
    R4_Out  = 1; chk_bus(32'h0, "rst_r4");

    // Register loads through MDR.
    MData_In = 32'h22; Read = 1; MDR_In = 1; step();
    MDR_Out = 1; R2_In = 1; chk_bus(32'h22, "mdr_to_r2");
    R2_Out = 1; chk_bus(32'h22, "r2_out");
    MData_In = 32'h24; Read = 1; MDR_In = 1; step();
    MDR_Out = 1; R4_In = 1; chk_bus(32'h24, "mdr_to_r4");
    R4_Out = 1; chk_bus(32'h24, "r4_out");

    // Fetch.
    PC_Out = 1; MAR_In = 1; IncPC = 1; Z_In = 1; chk_bus(32'h0, "fetch_pc");
    MData_In = 32'h4A92_0000;
    ZLO_Out = 1; PC_In = 1; Read = 1; MDR_In = 1; chk_bus(32'h1, "fetch_zlo");
    MDR_Out = 1; IR_In = 1; chk_bus(32'h4A92_0000, "fetch_ir");
    PC_Out = 1; chk_bus(32'h1, "fetch_pc_new");

    // AND R2, R4 into R5.
    R2_Out = 1; Y_In = 1; chk_bus(32'h22, "and_y");
    R4_Out = 1; CONTROL = 5'd1; Z_In = 1; chk_bus(32'h24, "and_b");
    ZLO_Out = 1; R5_In = 1; chk_bus(32'h20, "and_zlo");
    chk_zhi(32'h0, "and_zhi");

    // ALU operations and corners.
    alu_op(32'hFFFF_FFFF, 32'h1,         5'd0,  0, 32'h0,         32'h0,         "add_wrap");
    alu_op(32'h0001_0000, 32'h0001_0000, 5'd4,  0, 32'h0,         32'h1,         "mul_big");
    alu_op(32'hFFFF_FFFE, 32'h3,         5'd4,  0, 32'hFFFF_FFFA, 32'hFFFF_FFFF, "mul_neg");
    alu_op(32'hFFFF_FFF9, 32'h2,         5'd5,  0, 32'hFFFF_FFFD, 32'hFFFF_FFFF, "div_neg");
    alu_op(32'h1,         32'h21,        5'd9,  0, 32'h8000_0000, 32'h0,         "ror");
    alu_op(32'h8000_0001, 32'h1,         5'd10, 0, 32'h3,         32'h0,         "rol");
    alu_op(32'h5,         32'h7,         5'd3,  0, 32'hFFFF_FFFE, 32'h0,         "sub");
    alu_op(32'h8000_0000, 32'h4,         5'd8,  0, 32'hF800_0000, 32'h0,         "shra");
    alu_op(32'h8000_0000, 32'h1F,        5'd6,  0, 32'h1,         32'h0,         "shr");
    alu_op(32'h1,         32'h1F,        5'd7,  0, 32'h8000_0000, 32'h0,         "shl");
    alu_op(32'hF0,        32'h0F,        5'd2,  0, 32'hFF,        32'h0,         "or");
    alu_op(32'h9,         32'h1,         5'd11, 0, 32'hFFFF_FFFF, 32'h0,         "neg");
    alu_op(32'h9,         32'h0F0F_0F0F, 5'd12, 0, 32'hF0F0_F0F0, 32'h0,         "not");
    alu_op(32'h3,         32'h4,         5'd13, 0, 32'h0,         32'h0,         "op13");
    alu_op(32'h3,         32'h7,         5'd4,  1, 32'h8,         32'h0,         "incpc");
    alu_op(32'h5,         32'h0,         5'd5,  0, 32'hFFFF_FFFF, 32'h5,         "div_zero");

    // Bus priority.
    MData_In = 32'h5A5A_0000; Read = 1; MDR_In = 1; step();
    MDR_Out = 1; R2_Out = 1; chk_bus(32'h5A5A_0000, "prio_mdr_r2");
    MDR_Out = 1; ZLO_Out = 1; PC_Out = 1; chk_bus(32'h5A5A_0000, "prio_mdr_all");
    ZLO_Out = 1; PC_Out = 1; R2_Out = 1; R4_Out = 1; chk_bus(32'hFFFF_FFFF, "prio_zlo");
    PC_Out = 1; R2_Out = 1; R4_Out = 1; chk_bus(32'h1, "prio_pc");
    R2_Out = 1; R4_Out = 1; chk_bus(32'h22, "prio_r2");

    // Same register as source and destination.
    PC_Out = 1; PC_In = 1; chk_bus(32'h1, "pc_self_load");
    PC_Out = 1; chk_bus(32'h1, "pc_after_self");

    // Clear pulsed between edges clears registers before the next edge.
    R2_Out = 1;
    begin
      exp_t e;
      e.is_zhi = 1'b0; e.exp = 32'h0; e.name = "clr_mid_r2";
      sb_q.push_back(e);
    end
    obs_valid = 1'b1;
    #1 Clear = 1'b1;
    #1 Clear = 1'b0;
    @(posedge Clock);
    #1;
    obs_valid = 1'b0;
    clr_ctl();
    chk_zhi(32'h0, "clr_zhi");
    PC_Out = 1;  chk_bus(32'h0, "clr_pc");
    MDR_Out = 1; chk_bus(32'h0, "clr_mdr");
    ZLO_Out = 1; chk_bus(32'h0, "clr_zlo");
    R4_Out = 1;  chk_bus(32'h0, "clr_r4");

    step();
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
